rr_req_arbiter: RTL



---
 rtl/rr_req_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter sharing one downstream req/ack target among NUM_MASTERS
// requesters, with a per-transfer timeout that aborts and flags err.
module rr_req_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int IDW         = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        req,
  input  logic [NUM_MASTERS*DATA_W-1:0] data,
  output logic [NUM_MASTERS-1:0]        ack,
  output logic                          slv_req,
  output logic [DATA_W-1:0]             slv_data,
  input  logic                          slv_ack,
  output logic [IDW-1:0]                gnt_id,
  output logic                          busy,
  output logic                          err
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, ACK, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic [IDW-1:0]           ptr, ptr_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [NUM_MASTERS-1:0]   ack_nxt;
  logic                     slv_req_nxt, busy_nxt, err_nxt;
  logic [DATA_W-1:0]        slv_data_nxt;
  logic [IDW-1:0]           gnt_id_nxt;
  logic                     win_vld;
  logic [IDW-1:0]           win_idx;
  logic [DATA_W-1:0]        win_data;
  logic                     timeout_hit;

  // Scan ptr, ptr+1, ... modulo NUM_MASTERS; index never exceeds NUM_MASTERS-1.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_c;
    win_vld  = 1'b0;
    win_idx  = '0;
    win_data = '0;
    idx      = 0;
    idx_c    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      idx_c = IDW'(idx);
      if (!win_vld && req[idx_c]) begin
        win_vld = 1'b1;
        win_idx = idx_c;
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win_idx == IDW'(i)) win_data = data[i*DATA_W +: DATA_W];
    end
  end

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    cnt_nxt      = cnt;
    ack_nxt      = ack;
    slv_req_nxt  = slv_req;
    slv_data_nxt = slv_data;
    gnt_id_nxt   = gnt_id;
    busy_nxt     = busy;
    err_nxt      = err;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt    = BUSY;
          gnt_id_nxt   = win_idx;
          slv_data_nxt = win_data;
          slv_req_nxt  = 1'b1;
          busy_nxt     = 1'b1;
          cnt_nxt      = '0;
        end
      end
      BUSY: begin
        cnt_nxt = cnt + 1'b1;
        // slv_ack takes precedence over a timeout landing on the same edge
        if (slv_ack || timeout_hit) begin
          state_nxt   = ACK;
          slv_req_nxt = 1'b0;
          ack_nxt     = NUM_MASTERS'(1) << gnt_id;
          err_nxt     = !slv_ack;
          ptr_nxt     = (gnt_id == IDW'(NUM_MASTERS - 1)) ? '0 : gnt_id + 1'b1;
        end
      end
      ACK: begin
        state_nxt = DRAIN;
        ack_nxt   = '0;
        err_nxt   = 1'b0;
      end
      DRAIN: begin
        // hold off until the served master releases req so it is not regranted
        if (!req[gnt_id]) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      ack      <= '0;
      slv_req  <= 1'b0;
      slv_data <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      ack      <= ack_nxt;
      slv_req  <= slv_req_nxt;
      slv_data <= slv_data_nxt;
      gnt_id   <= gnt_id_nxt;
      busy     <= busy_nxt;
      err      <= err_nxt;
    end
  end

endmodule
